// File: rtl/character_motion_controller_pkg.sv
//------------------------------------------------------------------------------
// pacman_defs -- shared directions, sprite codes, FSM states and pixel helper. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pacman_defs;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    localparam logic [2:0] SPRITE_EMPTY  = 3'd0;
    localparam logic [2:0] SPRITE_WALL   = 3'd1;
    localparam logic [2:0] SPRITE_PELLET = 3'd2;

    localparam int DEF_TILE_SIZE = 5;
    localparam int DEF_MAP_W     = 21;
    localparam int DEF_MAP_H     = 21;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DISP = 3'd1,
        ST_Q_REQ     = 3'd2,
        ST_W_REQ     = 3'd3,
        ST_Q_CUR     = 3'd4,
        ST_W_CUR     = 3'd5,
        ST_STEP      = 3'd6,
        ST_OUT       = 3'd7
    } cmc_state_t;

    // Right/left and up/down differ only in bit 0.
    function automatic dir_t dir_opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

    function automatic logic [7:0] tile_to_pix(input logic [7:0] origin,
                                               input logic [4:0] tile,
                                               input logic [7:0] tile_size,
                                               input logic [7:0] off);
        return origin + ({3'b000, tile} * tile_size) + off;
    endfunction

endpackage

`default_nettype wire

// File: rtl/character_motion_controller_if.sv
//------------------------------------------------------------------------------
// character_motion_controller_if -- control, map query and position bus. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface character_motion_controller_if;
    logic       en;
    logic       move_tick;
    logic       is_display_running;
    logic [1:0] dir_req;
    logic       dir_req_valid;
    logic [4:0] map_x;
    logic [4:0] map_y;
    logic [2:0] sprite_type;
    logic [7:0] char_vga_x;
    logic [7:0] char_vga_y;
    logic       orientation;
    logic       is_moving;
    logic       step_done;
    logic       tick_dropped;

    modport master (
        input  en, move_tick, is_display_running, dir_req, dir_req_valid, sprite_type,
        output map_x, map_y, char_vga_x, char_vga_y, orientation, is_moving,
               step_done, tick_dropped
    );

    modport slave (
        output en, move_tick, is_display_running, dir_req, dir_req_valid, sprite_type,
        input  map_x, map_y, char_vga_x, char_vga_y, orientation, is_moving,
               step_done, tick_dropped
    );
endinterface

`default_nettype wire

// File: rtl/character_motion_controller_tile_neighbour.sv
//------------------------------------------------------------------------------
// tile_neighbour -- wrapped adjacent tile of (tile_x, tile_y) in direction dir. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tile_neighbour
    import pacman_defs::*;
#(
    parameter int MAP_W = DEF_MAP_W,
    parameter int MAP_H = DEF_MAP_H
) (
    input  logic [4:0] tile_x_i,
    input  logic [4:0] tile_y_i,
    input  dir_t       dir_i,
    output logic [4:0] nb_x_o,
    output logic [4:0] nb_y_o
);
    localparam logic [4:0] LAST_X = 5'(MAP_W - 1);
    localparam logic [4:0] LAST_Y = 5'(MAP_H - 1);

    always_comb begin
        nb_x_o = tile_x_i;
        nb_y_o = tile_y_i;
        case (dir_i)
            DIR_RIGHT: nb_x_o = (tile_x_i == LAST_X) ? 5'd0 : tile_x_i + 5'd1;
            DIR_LEFT:  nb_x_o = (tile_x_i == 5'd0) ? LAST_X : tile_x_i - 5'd1;
            DIR_UP:    nb_y_o = (tile_y_i == 5'd0) ? LAST_Y : tile_y_i - 5'd1;
            DIR_DOWN:  nb_y_o = (tile_y_i == LAST_Y) ? 5'd0 : tile_y_i + 5'd1;
            default: begin
                nb_x_o = tile_x_i;
                nb_y_o = tile_y_i;
            end
        endcase
    end
endmodule

`default_nettype wire

// File: rtl/character_motion_controller.sv
//------------------------------------------------------------------------------
// character_motion_controller -- steps one character through the tile map. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module character_motion_controller
    import pacman_defs::*;
#(
    parameter int TILE_SIZE   = DEF_TILE_SIZE,
    parameter int MAP_W       = DEF_MAP_W,
    parameter int MAP_H       = DEF_MAP_H,
    parameter int START_TX    = 10,
    parameter int START_TY    = 15,
    parameter int ORIGIN_X    = 0,
    parameter int ORIGIN_Y    = 0,
    parameter int MAP_LATENCY = 1
) (
    input  logic                          clock_50,
    input  logic                          reset,
    character_motion_controller_if.master bus
);
    localparam int               OFF_W     = (TILE_SIZE > 2) ? $clog2(TILE_SIZE) : 1;
    localparam logic [OFF_W-1:0] OFF_LAST  = OFF_W'(TILE_SIZE - 1);
    localparam logic [OFF_W-1:0] OFF_ONE   = OFF_W'(1);
    localparam logic [3:0]       LAT       = 4'(MAP_LATENCY);
    localparam logic [4:0]       START_X5  = 5'(START_TX);
    localparam logic [4:0]       START_Y5  = 5'(START_TY);
    localparam logic [7:0]       TS8       = 8'(TILE_SIZE);
    localparam logic [7:0]       ORG_X8    = 8'(ORIGIN_X);
    localparam logic [7:0]       ORG_Y8    = 8'(ORIGIN_Y);
    localparam logic [7:0]       RST_PIX_X = 8'(ORIGIN_X + START_TX * TILE_SIZE);
    localparam logic [7:0]       RST_PIX_Y = 8'(ORIGIN_Y + START_TY * TILE_SIZE);

    cmc_state_t       state_q, state_d;
    logic [4:0]       tile_x_q, tile_x_d;
    logic [4:0]       tile_y_q, tile_y_d;
    logic [OFF_W-1:0] offset_q, offset_d;
    dir_t             cur_dir_q, cur_dir_d;
    dir_t             req_dir_q, req_dir_d;
    logic             req_valid_q, req_valid_d;
    logic             is_moving_q, is_moving_d;
    logic             orient_q, orient_d;
    logic [4:0]       map_x_q, map_x_d;
    logic [4:0]       map_y_q, map_y_d;
    logic [3:0]       wait_q, wait_d;
    logic [7:0]       vga_x_q, vga_x_d;
    logic [7:0]       vga_y_q, vga_y_d;
    logic             step_done_q, step_done_d;
    logic             tick_dropped_q, tick_dropped_d;

    logic             w_aligned;
    logic             w_horiz;
    dir_t             w_nb_dir;
    logic [4:0]       w_nb_x;
    logic [4:0]       w_nb_y;
    logic [7:0]       w_off8;

    assign w_aligned = (offset_q == '0);
    assign w_horiz   = (cur_dir_q == DIR_RIGHT) || (cur_dir_q == DIR_LEFT);
    assign w_off8    = 8'(offset_q);
    // One neighbour unit serves both the map query and the tile carry in STEP.
    assign w_nb_dir  = (state_q == ST_Q_REQ) ? req_dir_q : cur_dir_q;

    tile_neighbour #(
        .MAP_W (MAP_W),
        .MAP_H (MAP_H)
    ) u_tile_neighbour (
        .tile_x_i (tile_x_q),
        .tile_y_i (tile_y_q),
        .dir_i    (w_nb_dir),
        .nb_x_o   (w_nb_x),
        .nb_y_o   (w_nb_y)
    );

    always_comb begin
        state_d        = state_q;
        tile_x_d       = tile_x_q;
        tile_y_d       = tile_y_q;
        offset_d       = offset_q;
        cur_dir_d      = cur_dir_q;
        req_dir_d      = req_dir_q;
        req_valid_d    = req_valid_q;
        is_moving_d    = is_moving_q;
        orient_d       = orient_q;
        map_x_d        = map_x_q;
        map_y_d        = map_y_q;
        wait_d         = wait_q;
        vga_x_d        = vga_x_q;
        vga_y_d        = vga_y_q;
        step_done_d    = 1'b0;
        tick_dropped_d = bus.move_tick && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (bus.move_tick && bus.en) begin
                    req_dir_d   = dir_t'(bus.dir_req);
                    req_valid_d = bus.dir_req_valid;
                    state_d     = ST_WAIT_DISP;
                end
            end
            ST_WAIT_DISP: begin
                if (!bus.is_display_running) begin
                    if (!w_aligned) begin
                        // Mid-tile only a reversal is honoured, without a map lookup.
                        if (req_valid_q && (req_dir_q == dir_opposite(cur_dir_q))) begin
                            cur_dir_d = req_dir_q;
                        end
                        state_d = ST_STEP;
                    end else if (req_valid_q) begin
                        state_d = ST_Q_REQ;
                    end else if (is_moving_q) begin
                        state_d = ST_Q_CUR;
                    end else begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_Q_REQ, ST_Q_CUR: begin
                map_x_d = w_nb_x;
                map_y_d = w_nb_y;
                wait_d  = 4'd0;
                state_d = (state_q == ST_Q_REQ) ? ST_W_REQ : ST_W_CUR;
            end
            ST_W_REQ: begin
                if (wait_q == LAT) begin
                    if (bus.sprite_type != SPRITE_WALL) begin
                        cur_dir_d   = req_dir_q;
                        is_moving_d = 1'b1;
                        state_d     = ST_STEP;
                    end else if (is_moving_q) begin
                        state_d = ST_Q_CUR;
                    end else begin
                        state_d = ST_OUT;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_W_CUR: begin
                if (wait_q == LAT) begin
                    if (bus.sprite_type == SPRITE_WALL) begin
                        is_moving_d = 1'b0;
                        state_d     = ST_OUT;
                    end else begin
                        state_d = ST_STEP;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_STEP: begin
                case (cur_dir_q)
                    DIR_RIGHT, DIR_DOWN: begin
                        if (offset_q == OFF_LAST) begin
                            offset_d = '0;
                            if (cur_dir_q == DIR_RIGHT) tile_x_d = w_nb_x;
                            else                        tile_y_d = w_nb_y;
                        end else begin
                            offset_d = offset_q + OFF_ONE;
                        end
                    end
                    default: begin
                        if (offset_q == '0) begin
                            offset_d = OFF_LAST;
                            if (cur_dir_q == DIR_LEFT) tile_x_d = w_nb_x;
                            else                       tile_y_d = w_nb_y;
                        end else begin
                            offset_d = offset_q - OFF_ONE;
                        end
                    end
                endcase
                if (cur_dir_q == DIR_RIGHT) orient_d = 1'b0;
                if (cur_dir_q == DIR_LEFT)  orient_d = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                vga_x_d     = tile_to_pix(ORG_X8, tile_x_q, TS8, w_horiz ? w_off8 : 8'd0);
                vga_y_d     = tile_to_pix(ORG_Y8, tile_y_q, TS8, w_horiz ? 8'd0 : w_off8);
                step_done_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            tile_x_q       <= START_X5;
            tile_y_q       <= START_Y5;
            offset_q       <= '0;
            cur_dir_q      <= DIR_RIGHT;
            req_dir_q      <= DIR_RIGHT;
            req_valid_q    <= 1'b0;
            is_moving_q    <= 1'b0;
            orient_q       <= 1'b0;
            map_x_q        <= START_X5;
            map_y_q        <= START_Y5;
            wait_q         <= 4'd0;
            vga_x_q        <= RST_PIX_X;
            vga_y_q        <= RST_PIX_Y;
            step_done_q    <= 1'b0;
            tick_dropped_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tile_x_q       <= tile_x_d;
            tile_y_q       <= tile_y_d;
            offset_q       <= offset_d;
            cur_dir_q      <= cur_dir_d;
            req_dir_q      <= req_dir_d;
            req_valid_q    <= req_valid_d;
            is_moving_q    <= is_moving_d;
            orient_q       <= orient_d;
            map_x_q        <= map_x_d;
            map_y_q        <= map_y_d;
            wait_q         <= wait_d;
            vga_x_q        <= vga_x_d;
            vga_y_q        <= vga_y_d;
            step_done_q    <= step_done_d;
            tick_dropped_q <= tick_dropped_d;
        end
    end

    assign bus.map_x        = map_x_q;
    assign bus.map_y        = map_y_q;
    assign bus.char_vga_x   = vga_x_q;
    assign bus.char_vga_y   = vga_y_q;
    assign bus.orientation  = orient_q;
    assign bus.is_moving    = is_moving_q;
    assign bus.step_done    = step_done_q;
    assign bus.tick_dropped = tick_dropped_q;
endmodule

`default_nettype wire

// File: tb/tb_character_motion_controller.sv
//------------------------------------------------------------------------------
// tb_character_motion_controller -- vector table, corner sequences, random walk. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_character_motion_controller;
    import pacman_defs::*;

    localparam int TS = 5;
    localparam int NW = 21;
    localparam int NH = 21;
    localparam int PW = TS * NW;
    localparam int PH = TS * NH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    character_motion_controller_if mif();

    character_motion_controller dut (
        .clock_50 (clk),
        .reset    (rst),
        .bus      (mif)
    );

    // Map RAM with one cycle of read latency.
    logic [2:0] tb_map [0:NH-1][0:NW-1];
    always @(posedge clk) mif.sprite_type <= tb_map[mif.map_y][mif.map_x];

    int         vec_cnt = 0;
    int         mis_cnt = 0;
    int         sd_cnt = 0;
    int         mchg_cnt = 0;
    logic [4:0] pmx = 5'd0;
    logic [4:0] pmy = 5'd0;

    always @(posedge clk) begin
        if (mif.step_done === 1'b1) sd_cnt <= sd_cnt + 1;
        if (mif.map_x !== pmx || mif.map_y !== pmy) mchg_cnt <= mchg_cnt + 1;
        pmx <= mif.map_x;
        pmy <= mif.map_y;
    end

    // Reference: absolute pixel position on a torus of PW x PH pixels.
    int mpx, mpy, mdir;
    bit mmov, mor;

    typedef struct {
        logic [1:0] d;
        logic       v;
        int         ex;
        int         ey;
        int         emv;
        int         eor;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string nm, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mpx = 10 * TS; mpy = 15 * TS; mdir = 0; mmov = 0; mor = 0;
    endtask

    function automatic bit wall_at(input int d);
        int tx, ty;
        tx = mpx / TS;
        ty = mpy / TS;
        case (d)
            0: tx = (tx + 1) % NW;
            1: tx = (tx + NW - 1) % NW;
            2: ty = (ty + NH - 1) % NH;
            default: ty = (ty + 1) % NH;
        endcase
        return tb_map[ty][tx] == SPRITE_WALL;
    endfunction

    task automatic model_step();
        case (mdir)
            0: begin mpx = (mpx + 1) % PW;      mor = 0; end
            1: begin mpx = (mpx + PW - 1) % PW; mor = 1; end
            2: mpy = (mpy + PH - 1) % PH;
            default: mpy = (mpy + 1) % PH;
        endcase
    endtask

    task automatic model_tick(input int d, input bit v);
        bit aligned;
        aligned = (mpx % TS == 0) && (mpy % TS == 0);
        if (!aligned) begin
            if (v && d == (mdir ^ 1)) mdir = d;
            model_step();
        end else if (v && !wall_at(d)) begin
            mdir = d; mmov = 1; model_step();
        end else if (mmov) begin
            if (wall_at(mdir)) mmov = 0;
            else model_step();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mif.move_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic issue_tick(input logic [1:0] d, input logic v);
        @(negedge clk);
        mif.dir_req = d;
        mif.dir_req_valid = v;
        mif.move_tick = 1'b1;
        @(negedge clk);
        mif.move_tick = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        bit got;
        n = 0; got = 0;
        while (!got && n < 60) begin
            @(posedge clk); #1;
            got = (mif.step_done === 1'b1);
            n++;
        end
        if (!got) begin
            vec_cnt++;
            mis_cnt++;
            $display("FAIL %s_timeout: step_done got 0 expected 1 within 60 cycles", nm);
        end
    endtask

    task automatic tick(input logic [1:0] d, input logic v, input string nm);
        issue_tick(d, v);
        wait_done(nm);
        model_tick(int'(d), v);
    endtask

    task automatic chk_model(input string nm);
        chk({nm, "_x"}, mif.char_vga_x, mpx);
        chk({nm, "_y"}, mif.char_vga_y, mpy);
        chk({nm, "_mv"}, mif.is_moving, mmov);
        chk({nm, "_or"}, mif.orientation, mor);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sd0, mc0;
        mif.en = 1'b1;
        mif.move_tick = 1'b0;
        mif.is_display_running = 1'b0;
        mif.dir_req = 2'd0;
        mif.dir_req_valid = 1'b0;
        for (int y = 0; y < NH; y++)
            for (int x = 0; x < NW; x++)
                tb_map[y][x] = SPRITE_EMPTY;

        tbl[0]  = '{2'd0, 1'b1, 51, 75, 1, 0};
        tbl[1]  = '{2'd0, 1'b1, 52, 75, 1, 0};
        tbl[2]  = '{2'd0, 1'b1, 53, 75, 1, 0};
        tbl[3]  = '{2'd0, 1'b1, 54, 75, 1, 0};
        tbl[4]  = '{2'd0, 1'b1, 55, 75, 1, 0};
        tbl[5]  = '{2'd0, 1'b0, 56, 75, 1, 0};
        tbl[6]  = '{2'd2, 1'b1, 57, 75, 1, 0};
        tbl[7]  = '{2'd2, 1'b1, 58, 75, 1, 0};
        tbl[8]  = '{2'd1, 1'b1, 57, 75, 1, 1};
        tbl[9]  = '{2'd1, 1'b0, 56, 75, 1, 1};
        tbl[10] = '{2'd1, 1'b0, 55, 75, 1, 1};
        tbl[11] = '{2'd3, 1'b1, 55, 76, 1, 1};
        tbl[12] = '{2'd2, 1'b1, 55, 75, 1, 1};
        tbl[13] = '{2'd2, 1'b0, 55, 74, 1, 1};
        tbl[14] = '{2'd0, 1'b1, 55, 73, 1, 1};

        // Reset state
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        chk("rst_x", mif.char_vga_x, 50);
        chk("rst_y", mif.char_vga_y, 75);
        chk("rst_mv", mif.is_moving, 0);
        chk("rst_or", mif.orientation, 0);
        chk("rst_map_x", mif.map_x, 10);
        chk("rst_map_y", mif.map_y, 15);
        chk("rst_drop", mif.tick_dropped, 0);
        chk("rst_no_step_done", sd_cnt, 0);

        // Table-driven walk on an open map
        for (int i = 0; i < 15; i++) begin
            issue_tick(tbl[i].d, tbl[i].v);
            wait_done($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_x", i), mif.char_vga_x, tbl[i].ex);
            chk($sformatf("tbl%0d_y", i), mif.char_vga_y, tbl[i].ey);
            chk($sformatf("tbl%0d_mv", i), mif.is_moving, tbl[i].emv);
            chk($sformatf("tbl%0d_or", i), mif.orientation, tbl[i].eor);
        end

        // Wall directly right of the start tile
        tb_map[15][11] = SPRITE_WALL;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(2'd0, 1'b1, "wall");
            chk("wall_x", mif.char_vga_x, 50);
            chk("wall_mv", mif.is_moving, 0);
        end
        tb_map[15][11] = SPRITE_EMPTY;

        // Mid-tile turn is ignored, reversal is immediate with no query
        do_reset();
        tick(2'd0, 1'b1, "mid1");
        tick(2'd0, 1'b1, "mid2");
        mc0 = mchg_cnt;
        tick(2'd2, 1'b1, "mid_up");
        chk("mid_up_x", mif.char_vga_x, 53);
        chk("mid_up_y", mif.char_vga_y, 75);
        tick(2'd1, 1'b1, "mid_rev");
        chk("mid_rev_x", mif.char_vga_x, 52);
        chk("mid_rev_or", mif.orientation, 1);
        chk("mid_no_query", mchg_cnt - mc0, 0);

        // Wrap from column 0 to column 20
        do_reset();
        for (int i = 0; i < 50; i++) tick(2'd1, 1'b1, "wrap_walk");
        chk("wrap_at0_x", mif.char_vga_x, 0);
        tick(2'd1, 1'b1, "wrap");
        chk("wrap_x", mif.char_vga_x, 104);
        chk("wrap_or", mif.orientation, 1);
        tick(2'd1, 1'b0, "wrap2");
        chk("wrap2_x", mif.char_vga_x, 103);

        // Display busy holds processing; extra tick is dropped
        do_reset();
        mif.is_display_running = 1'b1;
        sd0 = sd_cnt;
        issue_tick(2'd0, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        chk("busy_hold_x", mif.char_vga_x, 50);
        chk("busy_no_done", sd_cnt - sd0, 0);
        @(negedge clk);
        mif.move_tick = 1'b1;
        @(posedge clk); #1;
        chk("busy_dropped", mif.tick_dropped, 1);
        @(negedge clk);
        mif.move_tick = 1'b0;
        @(posedge clk); #1;
        chk("busy_dropped_pulse", mif.tick_dropped, 0);
        @(negedge clk);
        mif.is_display_running = 1'b0;
        wait_done("busy");
        model_tick(0, 1'b1);
        chk("busy_after_x", mif.char_vga_x, 51);
        repeat (15) @(posedge clk);
        #1;
        chk("busy_one_done", sd_cnt - sd0, 1);

        // Reset while waiting on the map in the current-direction query
        do_reset();
        for (int i = 0; i < 5; i++) tick(2'd0, 1'b1, "pre_wcur");
        chk("pre_wcur_x", mif.char_vga_x, 55);
        issue_tick(2'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("wcur_rst_x", mif.char_vga_x, 50);
        chk("wcur_rst_mv", mif.is_moving, 0);
        chk("wcur_rst_map_x", mif.map_x, 10);
        rst = 1'b0;
        model_reset();

        // Disabled: tick ignored silently
        mif.en = 1'b0;
        sd0 = sd_cnt;
        issue_tick(2'd0, 1'b1);
        #1;
        chk("en_low_drop", mif.tick_dropped, 0);
        repeat (15) @(posedge clk);
        #1;
        chk("en_low_done", sd_cnt - sd0, 0);
        chk("en_low_x", mif.char_vga_x, 50);
        mif.en = 1'b1;

        // Random walk on a random maze against the reference
        for (int y = 0; y < NH; y++)
            for (int x = 0; x < NW; x++)
                tb_map[y][x] = ($urandom_range(0, 4) == 0) ? SPRITE_WALL :
                               ($urandom_range(0, 1) == 0) ? SPRITE_PELLET : SPRITE_EMPTY;
        tb_map[15][10] = SPRITE_EMPTY;
        do_reset();
        for (int i = 0; i < 250; i++) begin
            logic [1:0] d;
            logic       v;
            bit         busy;
            d = 2'($urandom_range(0, 3));
            v = ($urandom_range(0, 2) != 0);
            busy = ($urandom_range(0, 3) == 0);
            if (busy) begin
                @(negedge clk);
                mif.is_display_running = 1'b1;
            end
            issue_tick(d, v);
            if (busy) begin
                repeat ($urandom_range(2, 8)) @(posedge clk);
                #1;
                chk("rnd_busy_hold_x", mif.char_vga_x, mpx);
                @(negedge clk);
                mif.is_display_running = 1'b0;
            end
            wait_done("rnd");
            model_tick(int'(d), v);
            chk_model("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end
endmodule

`default_nettype wire
